// File: rtl/bcd_to_b16_decoder.sv
// Five-digit BCD to 16-bit binary converter, one digit per cycle (MSD first).
// Define BCD_SAT_EN to saturate value_out to 0xFFFF on overflow; otherwise it wraps modulo 2^16.
module bcd_to_b16_decoder (
   input  logic        sysclk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  D5_in,
   input  logic [3:0]  D4_in,
   input  logic [3:0]  D3_in,
   input  logic [3:0]  D2_in,
   input  logic [3:0]  D1_in,
   output logic [15:0] value_out,
   output logic        valid,
   output logic        busy,
   output logic        err,
   output logic        ovf
);

   // state | meaning
   // IDLE  | waiting for start; results held
   // ACCUM | folding one captured digit per cycle into acc (D5 first)
   typedef enum logic {IDLE, ACCUM} state_t;

`ifdef BCD_SAT_EN
   localparam logic SAT_EN = 1'b1;
`else
   localparam logic SAT_EN = 1'b0;
`endif

   state_t           state_q, state_d;
   logic [4:0][3:0]  dig_q, dig_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [19:0]      acc_q, acc_d;
   logic [15:0]      value_q, value_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic             ovf_q, ovf_d;

   logic [3:0]       cur_dig;
   logic [19:0]      acc_nxt;
   logic             any_bad;
   logic             over;

   always_comb begin
      case (cnt_q)
         3'd0:    cur_dig = dig_q[4];
         3'd1:    cur_dig = dig_q[3];
         3'd2:    cur_dig = dig_q[2];
         3'd3:    cur_dig = dig_q[1];
         default: cur_dig = dig_q[0];
      endcase
   end

   // acc*10 as (acc<<3)+(acc<<1); even with non-BCD nibbles the sum stays below 2^20
   assign acc_nxt = {acc_q[16:0], 3'b000} + {acc_q[18:0], 1'b0} + {16'h0000, cur_dig};
   assign any_bad = (dig_q[0] > 4'd9) | (dig_q[1] > 4'd9) | (dig_q[2] > 4'd9) |
                    (dig_q[3] > 4'd9) | (dig_q[4] > 4'd9);
   assign over    = |acc_nxt[19:16];

   always_comb begin
      state_d = state_q;
      dig_d   = dig_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      value_d = value_q;
      valid_d = 1'b0;
      busy_d  = busy_q;
      err_d   = err_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               dig_d   = {D5_in, D4_in, D3_in, D2_in, D1_in};
               acc_d   = 20'd0;
               cnt_d   = 3'd0;
               busy_d  = 1'b1;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            acc_d = acc_nxt;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd4) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               valid_d = 1'b1;
               err_d   = any_bad;
               ovf_d   = ~any_bad & over;
               if (any_bad)
                  value_d = 16'h0000;
               else if (over && SAT_EN)
                  value_d = 16'hFFFF;
               else
                  value_d = acc_nxt[15:0];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dig_q   <= '0;
         cnt_q   <= 3'd0;
         acc_q   <= 20'd0;
         value_q <= 16'h0000;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dig_q   <= dig_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         value_q <= value_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
      end
   end

   assign value_out = value_q;
   assign valid     = valid_q;
   assign busy      = busy_q;
   assign err       = err_q;
   assign ovf       = ovf_q;

endmodule

// File: doc/bcd_to_b16_decoder.md
BCD_TO_B16_DECODER -- requirements
Module: bcd_to_b16_decoder

Interface
Parameters: none.
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 sysclk  input  1  system clock; every register updates on its rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 start  input  1  single-cycle conversion request.
REQ-005 D5_in, D4_in, D3_in, D2_in, D1_in  input  4 each  BCD digits; D5 is the most significant digit and D1 the least significant.
REQ-006 value_out  output  16  binary result.
REQ-007 valid  output  1  one-cycle pulse when value_out, err and ovf are updated.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 err  output  1  a captured digit was greater than 9.
REQ-010 ovf  output  1  the decimal value was greater than 65535.

Function
REQ-011 The FSM SHALL have two states: IDLE and ACCUM.
REQ-012 In IDLE, start=1 at rising edge k SHALL do all of the following at that edge:
- capture all five digits into internal registers;
- clear the 20-bit accumulator and the digit counter;
- set busy=1;
- go to ACCUM.
REQ-013 In ACCUM, each edge SHALL compute acc = acc*10 + digit, using D5 at the first edge and D1 at the fifth edge.
REQ-014 Accumulator width SHALL be 20 bits, so the maximum value 99999 fits without internal wrap.
REQ-015 At edge k+5 the block SHALL update value_out, err and ovf, set valid=1, clear busy and return to IDLE.
- Latency from the start edge to the valid edge is 5 cycles.
REQ-016 valid SHALL be high for exactly one cycle, from edge k+5 to edge k+6.
REQ-017 value_out, err and ovf SHALL hold their values until the next completion or reset.
REQ-018 start while busy=1 SHALL be ignored, with no queuing and no restart.
REQ-019 A start in the same cycle that valid is high SHALL be accepted, because the FSM is in IDLE; back-to-back conversions occur every 6 cycles.
REQ-020 Input digit changes after the capture edge SHALL NOT affect the conversion in progress.
REQ-021 err SHALL be set if any captured digit is greater than 9.
- When err=1, value_out=0 and ovf=0, regardless of the accumulator value.
REQ-022 ovf SHALL be set when err=0 and the final accumulator is greater than 65535.
REQ-023 With ovf=0 and err=0, value_out SHALL equal acc[15:0] exactly.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force all of the following:
- state=IDLE;
- busy=0, valid=0, err=0, ovf=0;
- value_out=0x0000;
- accumulator=0, digit counter=0, captured digits=0.
REQ-025 Reset during ACCUM SHALL abort the conversion with no valid pulse; start is ignored while rst_n=0.
REQ-026 The first start SHALL be accepted at the first edge with rst_n=1.

Configuration
REQ-027 The macro BCD_SAT_EN SHALL select the overflow behaviour:
- defined: on ovf=1, value_out=0xFFFF (saturate);
- undefined: on ovf=1, value_out=acc[15:0] (modulo 2^16).
- In both cases ovf is still flagged.

Verification
REQ-028 Reset, then start with digits 6,5,5,3,5 -> valid exactly 5 cycles later, value_out=0xFFFF, err=0, ovf=0, busy high for 5 cycles.
REQ-029 Digits 9,9,9,9,9 -> ovf=1; value_out=0xFFFF with BCD_SAT_EN, 0x869F (34463) without it.
REQ-030 Digits 0,1,2,A,4 -> err=1, ovf=0, value_out=0x0000.
REQ-031 Digits 0,0,0,0,0, then start with 1,2,3,4,5 in the valid cycle -> first result 0x0000, second result 0x3039 (12345) 6 cycles after the first valid; a start at cycle+2 of the second conversion has no effect.
REQ-032 Digits 4,2,0,0,0 with rst_n=0 for one cycle at start+3 -> no valid pulse, all outputs 0; a new start with 0,0,0,4,2 -> value_out=0x002A.
REQ-033 Digits 1,0,0,0,0 captured, then inputs changed to 9,9,9,9,9 at start+1 -> value_out=0x2710 (10000).
